// File: rtl/pong_pkg.sv
// Screen geometry, paddle placement and ball timing shared by the Pong blocks,
// plus the ball FSM state type.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    GOAL  = 2'd2,
    HALT  = 2'd3
  } ball_state_t;

  localparam int H_RES      = 640;
  localparam int V_RES      = 480;
  localparam int BALL_SZ    = 8;
  localparam int PAD_W      = 8;
  localparam int PAD_H      = 64;
  localparam int P1_X       = 16;
  localparam int P2_X       = 616;
  localparam int SPEED      = 2;
  localparam int SERVE_WAIT = 60;
  localparam int WIN_HOLD   = 30;

  localparam int CNT_MAX = (SERVE_WAIT > WIN_HOLD) ? SERVE_WAIT : WIN_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [9:0] BALL_X0 = 10'((H_RES - BALL_SZ) / 2);
  localparam logic [9:0] BALL_Y0 = 10'((V_RES - BALL_SZ) / 2);
  localparam logic [9:0] BALL_Y_MAX = 10'(V_RES - BALL_SZ);
  localparam logic [9:0] P1_EDGE = 10'(P1_X + PAD_W);
  localparam logic [9:0] P2_EDGE = 10'(P2_X - BALL_SZ);

  // Motion arithmetic runs in 12-bit signed so a step past zero stays negative.
  localparam logic signed [11:0] SPEED_S   = 12'(SPEED);
  localparam logic signed [11:0] X_MAX_S   = 12'(H_RES - BALL_SZ);
  localparam logic signed [11:0] Y_MAX_S   = 12'(V_RES - BALL_SZ);
  localparam logic signed [11:0] P1_EDGE_S = 12'(P1_X + PAD_W);
  localparam logic signed [11:0] P2_EDGE_S = 12'(P2_X - BALL_SZ);

  // True when the ball's rows [ball_y, ball_y+BALL_SZ) meet the paddle's rows.
  function automatic logic pad_overlap(input logic [9:0] ball_y, input logic [9:0] pad_y);
    logic [11:0] by;
    logic [11:0] py;
    by = {2'b00, ball_y};
    py = {2'b00, pad_y};
    return (by < py + 12'(PAD_H)) && (by + 12'(BALL_SZ) > py);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating frame-tick counter with a terminal-count strobe, used for the
// serve rest and the win-flag hold.
module frame_timer #(
  parameter int W   = 6,
  parameter int MAX = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] count;

  // last fires on the tick that completes 'limit' ticks since the clear.
  assign last = tick && (count == limit - W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Pong ball: serves from centre, moves once per frame, bounces off walls and
// paddles, raises a held win flag on a goal and freezes when the game is over.
module ball_motion
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic [9:0] p1_pad_y,
  input  logic [9:0] p2_pad_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       p1_win,
  output logic       p2_win,
  output logic [1:0] dbg_state
);

  ball_state_t state;
  ball_state_t state_d;

  logic dir_x;  // 1 = moving right
  logic dir_y;  // 1 = moving down

  logic             timer_clear;
  logic             timer_last;
  logic [CNT_W-1:0] timer_limit;

  logic signed [11:0] x_s;
  logic signed [11:0] nx;
  logic signed [11:0] ny;
  logic [9:0]         y_next;
  logic               dir_y_next;
  logic               hit_p1;
  logic               hit_p2;
  logic               goal_p1;
  logic               goal_p2;

  assign dbg_state   = state;
  assign timer_clear = (state_d != state);
  assign timer_limit = (state == GOAL) ? CNT_W'(WIN_HOLD) : CNT_W'(SERVE_WAIT);

  frame_timer #(
    .W   (CNT_W),
    .MAX (CNT_MAX)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .tick  (frame_tick),
    .limit (timer_limit),
    .last  (timer_last)
  );

  // Candidate next position and the wall / paddle / goal events it triggers.
  always_comb begin
    x_s        = $signed({2'b00, ball_x});
    nx         = dir_x ? (x_s + SPEED_S) : (x_s - SPEED_S);
    ny         = dir_y ? ($signed({2'b00, ball_y}) + SPEED_S)
                       : ($signed({2'b00, ball_y}) - SPEED_S);
    y_next     = ny[9:0];
    dir_y_next = dir_y;
    if (ny <= 12'sd0) begin
      y_next     = '0;
      dir_y_next = 1'b1;
    end else if (ny >= Y_MAX_S) begin
      y_next     = BALL_Y_MAX;
      dir_y_next = 1'b0;
    end

    hit_p1  = !dir_x && (nx <= P1_EDGE_S) && (x_s >= P1_EDGE_S)
              && pad_overlap(ball_y, p1_pad_y);
    hit_p2  = dir_x && (nx >= P2_EDGE_S) && (x_s <= P2_EDGE_S)
              && pad_overlap(ball_y, p2_pad_y);
    goal_p2 = !hit_p1 && !hit_p2 && (nx <= 12'sd0);
    goal_p1 = !hit_p1 && !hit_p2 && !goal_p2 && (nx >= X_MAX_S);
  end

  always_comb begin
    state_d = state;
    if (game_over) begin
      state_d = HALT;
    end else begin
      case (state)
        SERVE:   if (frame_tick && timer_last) state_d = PLAY;
        PLAY:    if (frame_tick && (goal_p1 || goal_p2)) state_d = GOAL;
        GOAL:    if (frame_tick && timer_last) state_d = SERVE;
        HALT:    state_d = HALT;
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SERVE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ball_x <= BALL_X0;
      ball_y <= BALL_Y0;
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
      p1_win <= 1'b0;
      p2_win <= 1'b0;
    end else if (game_over) begin
      ball_x <= BALL_X0;
      ball_y <= BALL_Y0;
      p1_win <= 1'b0;
      p2_win <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (frame_tick) begin
            ball_y <= y_next;
            dir_y  <= dir_y_next;
            if (hit_p1) begin
              ball_x <= P1_EDGE;
              dir_x  <= 1'b1;
            end else if (hit_p2) begin
              ball_x <= P2_EDGE;
              dir_x  <= 1'b0;
            end else if (goal_p2) begin
              p2_win <= 1'b1;
            end else if (goal_p1) begin
              p1_win <= 1'b1;
            end else begin
              ball_x <= nx[9:0];
            end
          end
        end
        GOAL: begin
          // After a right-player goal the next serve heads right, and vice versa.
          if (frame_tick && timer_last) begin
            dir_x  <= p2_win;
            p1_win <= 1'b0;
            p2_win <= 1'b0;
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve timing, wall and paddle bounces,
// goal flag hold, game-over halt and reset during a goal.
module tb_ball_motion;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] p1_pad_y = 10'd0;
  logic [9:0] p2_pad_y = 10'd0;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       p1_win;
  logic       p2_win;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int k = 0;

  ball_motion dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .game_over  (game_over),
    .p1_pad_y   (p1_pad_y),
    .p2_pad_y   (p2_pad_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .p1_win     (p1_win),
    .p2_win     (p2_win),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    game_over = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
  endtask

  // One-cycle frame pulse; outputs are sampled on the following negedge.
  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic play_to(input int k_target);
    while (k < k_target) begin
      do_tick();
      k++;
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, ".x"}, 32'(ball_x), 32'(ex));
    check({tag, ".y"}, 32'(ball_y), 32'(ey));
  endtask

  task automatic serve_phase();
    tick_n(SERVE_WAIT - 1);
    check("serve_wait_state", 32'(dbg_state), 32'(SERVE));
    check_pos("serve_wait", 316, 236);
    do_tick();
    check("launch_state", 32'(dbg_state), 32'(PLAY));
    check_pos("launch_tick", 316, 236);
  endtask

  initial begin
    // Scenario A: serve, bottom wall, right paddle, top wall, left paddle, right goal.
    p1_pad_y = 10'd150;
    p2_pad_y = 10'd400;
    do_reset();
    check("rst_state", 32'(dbg_state), 32'(SERVE));
    check_pos("rst", 316, 236);
    check("rst_p1_win", 32'(p1_win), 0);
    check("rst_p2_win", 32'(p2_win), 0);
    serve_phase();
    play_to(1);
    check_pos("first_move", 318, 238);
    play_to(117);
    check_pos("pre_bottom", 550, 470);
    play_to(118);
    check_pos("bottom_clamp", 552, 472);
    play_to(119);
    check_pos("after_bottom", 554, 470);
    play_to(146);
    check_pos("p2_hit", 608, 416);
    play_to(147);
    check_pos("after_p2_hit", 606, 414);
    play_to(353);
    check_pos("pre_top", 194, 2);
    play_to(354);
    check_pos("top_clamp", 192, 0);
    play_to(355);
    check_pos("after_top", 190, 2);
    play_to(437);
    check_pos("pre_p1", 26, 166);
    play_to(438);
    check_pos("p1_hit", 24, 168);
    check("p1_hit_no_p2_win", 32'(p2_win), 0);
    check("p1_hit_state", 32'(dbg_state), 32'(PLAY));
    play_to(439);
    check_pos("after_p1_hit", 26, 170);
    p2_pad_y = 10'd0;
    play_to(741);
    check("pre_goal1_state", 32'(dbg_state), 32'(PLAY));
    check("pre_goal1_x", 32'(ball_x), 630);
    play_to(742);
    check("goal1_p1_win", 32'(p1_win), 1);
    check("goal1_p2_win", 32'(p2_win), 0);
    check("goal1_state", 32'(dbg_state), 32'(GOAL));
    tick_n(5);
    check("goal1_hold", 32'(p1_win), 1);
    check("goal1_frozen_x", 32'(ball_x), 630);
    // Reset in the middle of the hold drops the flag on the next clock.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_goal_p1_win", 32'(p1_win), 0);
    check("rst_goal_state", 32'(dbg_state), 32'(SERVE));
    check_pos("rst_goal", 316, 236);
    rst = 1'b0;

    // Scenario B: ball leaves past the left edge with the left paddle away.
    p1_pad_y = 10'd400;
    p2_pad_y = 10'd400;
    do_reset();
    serve_phase();
    play_to(449);
    check_pos("pre_goal2", 2, 190);
    check("pre_goal2_p2_win", 32'(p2_win), 0);
    play_to(450);
    check("goal2_p2_win", 32'(p2_win), 1);
    check("goal2_p1_win", 32'(p1_win), 0);
    check("goal2_state", 32'(dbg_state), 32'(GOAL));
    for (int i = 1; i < WIN_HOLD; i++) begin
      do_tick();
      check($sformatf("goal2_hold_%0d", i), 32'(p2_win), 1);
    end
    do_tick();
    check("goal2_release", 32'(p2_win), 0);
    check("goal2_release_p1", 32'(p1_win), 0);
    check("goal2_release_state", 32'(dbg_state), 32'(SERVE));
    check_pos("goal2_recentre", 316, 236);
    for (int i = 1; i < SERVE_WAIT; i++) begin
      do_tick();
      if (p1_win || p2_win) check($sformatf("serve2_flags_%0d", i), 32'({p1_win, p2_win}), 0);
    end
    check("serve2_state", 32'(dbg_state), 32'(SERVE));
    check_pos("serve2_rest", 316, 236);
    do_tick();
    check("relaunch_state", 32'(dbg_state), 32'(PLAY));
    do_tick();
    check_pos("relaunch_move", 318, 238);

    // Scenario C: game over mid-play halts and centres without a tick.
    p1_pad_y = 10'd0;
    p2_pad_y = 10'd0;
    do_reset();
    tick_n(SERVE_WAIT);
    k = 0;
    play_to(3);
    check_pos("pre_halt", 322, 242);
    @(negedge clk);
    game_over = 1'b1;
    @(negedge clk);
    check("halt_state", 32'(dbg_state), 32'(HALT));
    check_pos("halt_entry", 316, 236);
    check("halt_flags", 32'({p1_win, p2_win}), 0);
    tick_n(200);
    check("halt_state_200", 32'(dbg_state), 32'(HALT));
    check_pos("halt_200", 316, 236);
    game_over = 1'b0;
    tick_n(5);
    check("halt_sticky", 32'(dbg_state), 32'(HALT));
    check_pos("halt_sticky", 316, 236);
    do_reset();
    check("final_rst_state", 32'(dbg_state), 32'(SERVE));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
